// File: rtl/mem_access_pkg.sv
// Shared constants, FSM state and size decode for the memory-access stage.
// Opcodes are instruction bits [6:2].
package mem_access_pkg;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_REG   = 5'b01100;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_WB
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Any funct3 that is not a byte or half form is a word access.
  function automatic size_t size_of(input logic [2:0] f3);
    size_t sz;
    sz = SZ_W;
    if (f3[1:0] == 2'b00) sz = SZ_B;
    else if (f3[1:0] == 2'b01) sz = SZ_H;
    return sz;
  endfunction

  function automatic logic aligned(input size_t sz,
                                   input logic [1:0] lo);
    logic ok;
    ok = 1'b1;
    if (sz == SZ_H) ok = ~lo[0];
    else if (sz == SZ_W) ok = (lo == 2'b00);
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Upstream, data-memory and writeback signals of the memory-access stage.
// master drives the stage inputs, slave is the stage itself.
interface mem_access_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [4:0]      opcode_i;
  logic [2:0]      funct3_i;
  logic [4:0]      rd_idx_i;
  logic [XLEN-1:0] alu_result_i;
  logic [XLEN-1:0] store_data_i;
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic [3:0]      dmem_be_o;
  logic            dmem_gnt_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;
  logic            wb_valid_o;
  logic [4:0]      wb_rd_o;
  logic [XLEN-1:0] wb_data_o;
  logic            misalign_o;

  modport master (
    output valid_i, opcode_i, funct3_i, rd_idx_i,
    output alu_result_i, store_data_i,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  ready_o, dmem_req_o, dmem_we_o,
    input  dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, misalign_o
  );

  modport slave (
    input  valid_i, opcode_i, funct3_i, rd_idx_i,
    input  alu_result_i, store_data_i,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output ready_o, dmem_req_o, dmem_we_o,
    output dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output wb_valid_o, wb_rd_o, wb_data_o, misalign_o
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Load lane extract with sign/zero extension.
// Ports: rdata (memory word), off (byte offset), funct3, data (result).
module mem_access_load_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{off, 3'b000} +: 8];
  assign lane_h = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    data = rdata;
    unique case (size_of(funct3))
      SZ_B: data = funct3[2]
                 ? {{(XLEN-8){1'b0}}, lane_b}
                 : {{(XLEN-8){lane_b[7]}}, lane_b};
      SZ_H: data = funct3[2]
                 ? {{(XLEN-16){1'b0}}, lane_h}
                 : {{(XLEN-16){lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores to data memory, forwards ALU
// results to writeback. Ports: clk, rst_n (sync, active-low), bus (slave).
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);

  state_t          state_q;
  logic            ready_q;
  logic            req_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;
  logic            wb_valid_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic            misalign_q;
  logic [1:0]      off_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;

  logic            xfer;
  logic            is_mem;
  logic            is_st;
  logic            ok;
  logic [1:0]      lo;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] ld_data;

  assign xfer   = bus.valid_i && ready_q;
  assign is_st  = (bus.opcode_i == OP_STORE);
  assign is_mem = is_st || (bus.opcode_i == OP_LOAD);
  assign lo     = bus.alu_result_i[1:0];
  assign ok     = aligned(size_of(bus.funct3_i), lo);

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = bus.store_data_i;
    unique case (size_of(bus.funct3_i))
      SZ_B: begin
        be_c    = 4'b0001 << lo;
        wdata_c = {(XLEN/8){bus.store_data_i[7:0]}};
      end
      SZ_H: begin
        be_c    = lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {(XLEN/16){bus.store_data_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = bus.store_data_i;
      end
    endcase
  end

  mem_access_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata (bus.dmem_rdata_i),
    .off   (off_q),
    .funct3(f3_q),
    .data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      off_q      <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
    end else begin
      misalign_q <= 1'b0;
      wb_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (xfer) begin
            if (!is_mem) begin
              state_q    <= S_WB;
              ready_q    <= 1'b0;
              wb_valid_q <= (bus.rd_idx_i != 5'd0);
              wb_rd_q    <= bus.rd_idx_i;
              wb_data_q  <= bus.alu_result_i;
            end else if (!ok) begin
              misalign_q <= 1'b1;
            end else begin
              state_q <= S_REQ;
              ready_q <= 1'b0;
              req_q   <= 1'b1;
              we_q    <= is_st;
              addr_q  <= {bus.alu_result_i[XLEN-1:2], 2'b00};
              wdata_q <= wdata_c;
              be_q    <= be_c;
              off_q   <= lo;
              f3_q    <= bus.funct3_i;
              rd_q    <= bus.rd_idx_i;
            end
          end
        end
        S_REQ: begin
          if (bus.dmem_gnt_i) begin
            req_q <= 1'b0;
            if (we_q) begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.dmem_rvalid_i) begin
            state_q    <= S_WB;
            wb_valid_q <= (rd_q != 5'd0);
            wb_rd_q    <= rd_q;
            wb_data_q  <= ld_data;
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.dmem_req_o   = req_q;
  assign bus.dmem_we_o    = we_q;
  assign bus.dmem_addr_o  = addr_q;
  assign bus.dmem_wdata_o = wdata_q;
  assign bus.dmem_be_o    = be_q;
  assign bus.wb_valid_o   = wb_valid_q;
  assign bus.wb_rd_o      = wb_rd_q;
  assign bus.wb_data_o    = wb_data_q;
  assign bus.misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus random transactions
// checked against an arithmetic reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_if #(.XLEN(32)) bus ();

  mem_access #(.XLEN(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input int off,
                                         input logic [31:0] rd);
    int n;
    longint v;
    longint span;
    n = nbytes(f3);
    if (n == 4) return rd;
    span = longint'(1) << (8 * n);
    v = (longint'(rd) >> (8 * off)) % span;
    if (f3[2] == 1'b0 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] f3, input int off);
    int n;
    n = nbytes(f3);
    if (n == 1) return 32'(1 << off);
    if (n == 2) return 32'(3 << off);
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] sd);
    int n;
    n = nbytes(f3);
    if (n == 1) return (sd % 256) * 32'h0101_0101;
    if (n == 2) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready_o), 32'd0);
    chk({tag, "_req"}, 32'(bus.dmem_req_o), 32'd0);
    chk({tag, "_we"}, 32'(bus.dmem_we_o), 32'd0);
    chk({tag, "_addr"}, bus.dmem_addr_o, 32'd0);
    chk({tag, "_wdata"}, bus.dmem_wdata_o, 32'd0);
    chk({tag, "_be"}, 32'(bus.dmem_be_o), 32'd0);
    chk({tag, "_wbv"}, 32'(bus.wb_valid_o), 32'd0);
    chk({tag, "_wbrd"}, 32'(bus.wb_rd_o), 32'd0);
    chk({tag, "_wbdata"}, bus.wb_data_o, 32'd0);
    chk({tag, "_mis"}, 32'(bus.misalign_o), 32'd0);
  endtask

  task automatic txn(input string tag,
                     input logic [4:0] op,
                     input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] sd,
                     input logic [4:0] rd,
                     input int gd,
                     input int rdl,
                     input logic [31:0] rdata);
    bit mem, st, al;
    logic [31:0] ea;
    mem = (op == OP_LOAD) || (op == OP_STORE);
    st = (op == OP_STORE);
    al = (a % nbytes(f3)) == 0;
    ea = a - (a % 4);
    chk({tag, "_rdy0"}, 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1;
    bus.opcode_i = op;
    bus.funct3_i = f3;
    bus.alu_result_i = a;
    bus.store_data_i = sd;
    bus.rd_idx_i = rd;
    step();
    bus.valid_i = 1'b0;
    bus.opcode_i = 5'($urandom);
    bus.alu_result_i = $urandom;
    if (!mem) begin
      chk({tag, "_wbv"}, 32'(bus.wb_valid_o), 32'(rd != 0));
      if (rd != 0) begin
        chk({tag, "_wbrd"}, 32'(bus.wb_rd_o), 32'(rd));
        chk({tag, "_wbd"}, bus.wb_data_o, a);
      end
      chk({tag, "_rdyw"}, 32'(bus.ready_o), 32'd0);
      step();
      chk({tag, "_wbv1"}, 32'(bus.wb_valid_o), 32'd0);
      chk({tag, "_rdy1"}, 32'(bus.ready_o), 32'd1);
    end else if (!al) begin
      chk({tag, "_mis"}, 32'(bus.misalign_o), 32'd1);
      chk({tag, "_req"}, 32'(bus.dmem_req_o), 32'd0);
      chk({tag, "_wbv"}, 32'(bus.wb_valid_o), 32'd0);
      chk({tag, "_rdy"}, 32'(bus.ready_o), 32'd1);
      step();
      chk({tag, "_mis1"}, 32'(bus.misalign_o), 32'd0);
      chk({tag, "_req1"}, 32'(bus.dmem_req_o), 32'd0);
    end else begin
      chk({tag, "_req"}, 32'(bus.dmem_req_o), 32'd1);
      chk({tag, "_we"}, 32'(bus.dmem_we_o), 32'(st));
      chk({tag, "_addr"}, bus.dmem_addr_o, ea);
      chk({tag, "_rdyr"}, 32'(bus.ready_o), 32'd0);
      if (st) begin
        chk({tag, "_be"}, 32'(bus.dmem_be_o), m_be(f3, int'(a % 4)));
        chk({tag, "_wdata"}, bus.dmem_wdata_o, m_wdata(f3, sd));
      end
      repeat (gd) begin
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i = $urandom;
        step();
        bus.dmem_rvalid_i = 1'b0;
        chk({tag, "_reqh"}, 32'(bus.dmem_req_o), 32'd1);
        chk({tag, "_addrh"}, bus.dmem_addr_o, ea);
      end
      bus.dmem_gnt_i = 1'b1;
      step();
      bus.dmem_gnt_i = 1'b0;
      chk({tag, "_reqg"}, 32'(bus.dmem_req_o), 32'd0);
      chk({tag, "_wbvg"}, 32'(bus.wb_valid_o), 32'd0);
      if (st) begin
        chk({tag, "_rdyg"}, 32'(bus.ready_o), 32'd1);
      end else begin
        repeat (rdl) begin
          bus.dmem_gnt_i = 1'b1;
          step();
          bus.dmem_gnt_i = 1'b0;
          chk({tag, "_reqw"}, 32'(bus.dmem_req_o), 32'd0);
          chk({tag, "_wbvw"}, 32'(bus.wb_valid_o), 32'd0);
        end
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i = rdata;
        step();
        bus.dmem_rvalid_i = 1'b0;
        chk({tag, "_wbv"}, 32'(bus.wb_valid_o), 32'(rd != 0));
        if (rd != 0) begin
          chk({tag, "_wbrd"}, 32'(bus.wb_rd_o), 32'(rd));
          chk({tag, "_wbd"}, bus.wb_data_o,
              m_load(f3, int'(a % 4), rdata));
        end
        step();
        chk({tag, "_wbv1"}, 32'(bus.wb_valid_o), 32'd0);
        chk({tag, "_rdy1"}, 32'(bus.ready_o), 32'd1);
      end
    end
  endtask

  initial begin
    logic [4:0] ops [5];
    bus.valid_i = 1'b0;
    bus.opcode_i = '0;
    bus.funct3_i = '0;
    bus.rd_idx_i = '0;
    bus.alu_result_i = '0;
    bus.store_data_i = '0;
    bus.dmem_gnt_i = 1'b0;
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i = '0;

    rst_n = 1'b0;
    repeat (3) step();
    check_all_zero("rst");
    rst_n = 1'b1;
    step();
    chk("rst_rel_ready", 32'(bus.ready_o), 32'd1);

    txn("imm7", OP_IMM, 3'b000, 32'h7, 0, 5'd5, 0, 0, 0);
    txn("reg", OP_REG, 3'b000, 32'hDEAD_BEEF, 0, 5'd31, 0, 0, 0);
    txn("reg_x0", OP_REG, 3'b000, 32'h1, 0, 5'd0, 0, 0, 0);
    txn("sb103", OP_STORE, F3_B, 32'h103, 32'hAB, 5'd0, 1, 0, 0);
    chk("sb103_be_k", 32'(bus.dmem_be_o), 32'h8);
    chk("sb103_wd_k", bus.dmem_wdata_o, 32'hABAB_ABAB);
    chk("sb103_ad_k", bus.dmem_addr_o, 32'h100);
    txn("lb102", OP_LOAD, F3_B, 32'h102, 0, 5'd7, 0, 1, 32'h0080_0000);
    chk("lb102_k", bus.wb_data_o, 32'hFFFF_FF80);
    txn("lbu102", OP_LOAD, F3_BU, 32'h102, 0, 5'd7, 0, 1, 32'h0080_0000);
    chk("lbu102_k", bus.wb_data_o, 32'h0000_0080);
    txn("lh101", OP_LOAD, F3_H, 32'h101, 0, 5'd3, 0, 0, 0);
    txn("sh102", OP_STORE, F3_H, 32'h102, 32'h1234_BEEF, 5'd0, 0, 0, 0);
    txn("sh100", OP_STORE, F3_H, 32'h100, 32'h1234_BEEF, 5'd0, 2, 0, 0);
    txn("sw", OP_STORE, F3_W, 32'h40, 32'hCAFE_F00D, 5'd1, 0, 0, 0);
    txn("lh_s", OP_LOAD, F3_H, 32'h2, 0, 5'd9, 0, 0, 32'h8001_7FFF);
    txn("lhu", OP_LOAD, F3_HU, 32'h2, 0, 5'd9, 0, 0, 32'h8001_7FFF);
    txn("ld_f3_3", OP_LOAD, 3'b011, 32'h204, 0, 5'd4, 0, 0, 32'h8765_4321);
    txn("st_f3_7", OP_STORE, 3'b111, 32'h206, 32'h1, 5'd0, 0, 0, 0);
    txn("lw_x0", OP_LOAD, F3_W, 32'h200, 0, 5'd0, 0, 0, 32'h1234_5678);

    bus.valid_i = 1'b1;
    bus.opcode_i = OP_LOAD;
    bus.funct3_i = F3_W;
    bus.alu_result_i = 32'h300;
    bus.rd_idx_i = 5'd6;
    step();
    bus.valid_i = 1'b0;
    bus.dmem_gnt_i = 1'b1;
    step();
    bus.dmem_gnt_i = 1'b0;
    rst_n = 1'b0;
    step();
    check_all_zero("rst_resp");
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i = 32'h5555_AAAA;
    step();
    check_all_zero("rst_resp2");
    rst_n = 1'b1;
    step();
    bus.dmem_rvalid_i = 1'b0;
    chk("rst_late_wbv", 32'(bus.wb_valid_o), 32'd0);
    chk("rst_late_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_late_rdy", 32'(bus.ready_o), 32'd1);
    txn("post_rst", OP_IMM, 3'b000, 32'h99, 0, 5'd2, 0, 0, 0);

    ops[0] = OP_LOAD;
    ops[1] = OP_STORE;
    ops[2] = OP_IMM;
    ops[3] = OP_REG;
    for (int i = 0; i < 300; i++) begin
      ops[4] = 5'($urandom);
      txn("rnd", ops[$urandom_range(0, 4)], 3'($urandom),
          $urandom, $urandom, 5'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
